hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 41 ++++
 rtl/hazard_shadow_reg.sv | 28 ++
 rtl/hazard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared CPU pipeline definitions: operand-forward encodings, the shadow-entry
// record tracked per stage, and the producer-match rule used by the hazard unit.
package hazard_unit_pkg;

  // Shadow entries carry register addresses at this width; narrower files are zero-extended.
  localparam int unsigned RD_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwen;
    logic            is_load;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{valid: 1'b0, rd: '0, regwen: 1'b0, is_load: 1'b0};

  // x0 is hard-wired zero, so an entry targeting it never supplies an operand.
  function automatic logic fwd_match(input shadow_t e, input logic [RD_W-1:0] src,
                                     input logic used);
    return used && e.valid && e.regwen && (e.rd != '0) && (e.rd == src);
  endfunction

  // The EX-shadow producer is younger than the MEM-shadow one, so it is checked first.
  function automatic fwd_sel_e fwd_pick(input shadow_t ex_e, input shadow_t mem_e,
                                        input logic [RD_W-1:0] src, input logic used);
    if (fwd_match(ex_e, src, used)) begin
      return FWD_MEM;
    end
    if (fwd_match(mem_e, src, used)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_shadow_reg.sv
// One pipeline shadow entry: freezes on hold, otherwise loads the upstream entry
// or a bubble.
module hazard_shadow_reg
  import hazard_unit_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_hold,
  input  logic    i_bubble,
  input  shadow_t i_d,
  output shadow_t o_q
);

  shadow_t r_q;

  // NOTE: state is updated with non-blocking assignments so every shadow samples
  // its upstream neighbour's pre-edge value; blocking here would collapse stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SHADOW_BUBBLE;
    end else if (!i_hold) begin
      r_q <= i_bubble ? SHADOW_BUBBLE : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB destination shadows, registers ALU
// forward selects, detects load-use stalls and counts stall/flush events.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwen,
  input  logic              id_is_load,
  input  logic              ex_flush,
  input  logic              ext_stall,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [RD_W-1:0] w_rs1;
  logic [RD_W-1:0] w_rs2;
  shadow_t         w_id_entry;
  shadow_t         w_ex;
  shadow_t         w_mem;
  shadow_t         w_wb;
  logic            w_load_use;
  logic            w_stall;
  logic            w_squash;
  fwd_sel_e        w_fwd_a;
  fwd_sel_e        w_fwd_b;
  logic            w_unused;

  fwd_sel_e         r_fwd_a;
  fwd_sel_e         r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_rs1 = RD_W'(id_rs1);
  assign w_rs2 = RD_W'(id_rs2);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_id_entry         = SHADOW_BUBBLE;
    w_id_entry.valid   = 1'b1;
    w_id_entry.rd      = RD_W'(id_rd);
    w_id_entry.regwen  = id_regwen;
    w_id_entry.is_load = id_is_load;
  end

  always_comb begin
    w_load_use = 1'b0;
    if (w_ex.valid && w_ex.is_load) begin
      w_load_use = fwd_match(w_ex, w_rs1, id_use_rs1) || fwd_match(w_ex, w_rs2, id_use_rs2);
    end
  end

  // A taken branch or a memory-side freeze both override the load-use stall.
  assign w_stall  = w_load_use && !ex_flush && !ext_stall;
  assign w_squash = w_stall || ex_flush;

  assign w_fwd_a = fwd_pick(w_ex, w_mem, w_rs1, id_use_rs1);
  assign w_fwd_b = fwd_pick(w_ex, w_mem, w_rs2, id_use_rs2);

  hazard_shadow_reg u_ex_shadow (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (ext_stall),
    .i_bubble (w_squash),
    .i_d      (w_id_entry),
    .o_q      (w_ex)
  );

  hazard_shadow_reg u_mem_shadow (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (ext_stall),
    .i_bubble (1'b0),
    .i_d      (w_ex),
    .o_q      (w_mem)
  );

  hazard_shadow_reg u_wb_shadow (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (ext_stall),
    .i_bubble (1'b0),
    .i_d      (w_mem),
    .o_q      (w_wb)
  );

  // The WB shadow is kept for pipeline bookkeeping; nothing forwards from it yet.
  assign w_unused = ^w_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
    end else if (!ext_stall) begin
      r_fwd_a <= w_squash ? FWD_NONE : w_fwd_a;
      r_fwd_b <= w_squash ? FWD_NONE : w_fwd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!ext_stall) begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (ex_flush) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign forwardA  = r_fwd_a;
  assign forwardB  = r_fwd_b;
  assign stall_id  = w_stall;
  assign bubble_ex = !w_ex.valid;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an instruction-level model.
module tb_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_regwen, id_is_load;
  logic              ex_flush, ext_stall;
  logic [1:0]        forwardA, forwardB;
  logic              stall_id, bubble_ex;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwen  (id_regwen),
    .id_is_load (id_is_load),
    .ex_flush   (ex_flush),
    .ext_stall  (ext_stall),
    .forwardA   (forwardA),
    .forwardB   (forwardB),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // Instructions older than ID, youngest first: [0]=EX, [1]=MEM, [2]=WB.
  typedef struct {
    bit valid;
    int rd;
    bit regwen;
    bit is_load;
  } instr_t;

  instr_t m_pipe[3];
  int     m_fa, m_fb, m_scnt, m_fcnt;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit produces(input int idx, input int src, input bit used);
    return used && m_pipe[idx].valid && m_pipe[idx].regwen &&
           m_pipe[idx].rd != 0 && m_pipe[idx].rd == src;
  endfunction

  // Distance of the youngest matching producer from EX picks the bypass point.
  function automatic int fwd_code(input int src, input bit used);
    for (int i = 0; i < 2; i++) begin
      if (produces(i, src, used)) return 2 - i;
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (rst || ext_stall || ex_flush) return 1'b0;
    return m_pipe[0].is_load &&
           (produces(0, int'(id_rs1), id_use_rs1) || produces(0, int'(id_rs2), id_use_rs2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{valid: 1'b0, rd: 0, regwen: 1'b0, is_load: 1'b0};
    m_fa = 0; m_fb = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic compare_all();
    check("stall_id",  32'(stall_id),  32'(exp_stall()));
    check("forwardA",  32'(forwardA),  m_fa);
    check("forwardB",  32'(forwardB),  m_fb);
    check("bubble_ex", 32'(bubble_ex), 32'(!m_pipe[0].valid));
    check("stall_cnt", 32'(stall_cnt), m_scnt);
    check("flush_cnt", 32'(flush_cnt), m_fcnt);
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit     st, fl;
    int     nfa, nfb;
    instr_t id;
    @(negedge clk);
    compare_all();
    st  = exp_stall();
    fl  = ex_flush;
    nfa = (st || fl) ? 0 : fwd_code(int'(id_rs1), id_use_rs1);
    nfb = (st || fl) ? 0 : fwd_code(int'(id_rs2), id_use_rs2);
    id  = '{valid: 1'b1, rd: int'(id_rd), regwen: id_regwen, is_load: id_is_load};
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!ext_stall) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      if (st || fl) m_pipe[0] = '{valid: 1'b0, rd: 0, regwen: 1'b0, is_load: 1'b0};
      else          m_pipe[0] = id;
      m_fa   = nfa;
      m_fb   = nfb;
      m_scnt = (m_scnt + int'(st)) % CNT_MOD;
      m_fcnt = (m_fcnt + int'(fl)) % CNT_MOD;
    end
    #1;
  endtask

  task automatic drive(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wen, input bit ld,
                       input bit fl = 1'b0, input bit xs = 1'b0);
    id_rs1 = REG_AW'(rs1); id_use_rs1 = u1;
    id_rs2 = REG_AW'(rs2); id_use_rs2 = u2;
    id_rd = REG_AW'(rd); id_regwen = wen; id_is_load = ld;
    ex_flush = fl; ext_stall = xs;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_forwardA",  32'(forwardA),  0);
    check("rst_forwardB",  32'(forwardB),  0);
    check("rst_bubble_ex", 32'(bubble_ex), 1);
    check("rst_stall_id",  32'(stall_id),  0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("init_bubble_ex", 32'(bubble_ex), 1);
    check("init_forwardA",  32'(forwardA),  0);
    step();
    rst = 1'b0;

    // add x5 in EX, consumer reads rs1=x5
    drive(0, 0, 0, 0, 5, 1, 0);
    step();
    drive(5, 1, 9, 0, 0, 0, 0);
    step();
    check("add_fwdA", 32'(forwardA), 2);
    check("add_fwdB", 32'(forwardB), 0);

    // lw x7 then consumer on rs2: one stall, bubble, then WB forward
    drive(0, 0, 0, 0, 7, 1, 1);
    step();
    drive(0, 0, 7, 1, 0, 0, 0);
    #1;
    check("lu_stall", 32'(stall_id), 1);
    step();
    check("lu_bubble",    32'(bubble_ex), 1);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_unstall",   32'(stall_id),  0);
    step();
    check("lu_fwdB", 32'(forwardB), 1);

    // x3 written by both EX and MEM shadows: younger producer wins
    drive(0, 0, 0, 0, 3, 1, 0);
    step();
    step();
    drive(3, 1, 3, 1, 0, 0, 0);
    step();
    check("prio_fwdA", 32'(forwardA), 2);
    check("prio_fwdB", 32'(forwardB), 2);

    // lw x0 never stalls or forwards
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    check("x0_stall", 32'(stall_id), 0);
    step();
    check("x0_fwdA", 32'(forwardA), 0);

    // flush concurrent with load-use: flush wins
    pulse_reset();
    drive(0, 0, 0, 0, 9, 1, 1);
    step();
    drive(9, 1, 0, 0, 0, 0, 0, 1'b1);
    #1;
    check("fl_stall", 32'(stall_id), 0);
    step();
    check("fl_bubble",    32'(bubble_ex), 1);
    check("fl_flush_cnt", 32'(flush_cnt), 1);
    check("fl_stall_cnt", 32'(stall_cnt), 0);

    // freeze during load-use, then reset aborts it
    drive(0, 0, 0, 0, 4, 1, 1);
    step();
    drive(4, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_stall",     32'(stall_id),  0);
      check("frz_bubble",    32'(bubble_ex), 0);
      check("frz_fwdA",      32'(forwardA),  0);
      check("frz_stall_cnt", 32'(stall_cnt), 0);
      check("frz_flush_cnt", 32'(flush_cnt), 1);
      step();
    end
    pulse_reset();
    drive(4, 1, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_stall", 32'(stall_id), 0);
    step();
    check("post_rst_fwdA",   32'(forwardA),  0);
    check("post_rst_bubble", 32'(bubble_ex), 0);

    // randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) pulse_reset();
      drive($urandom_range(3), $urandom_range(3) != 0,
            $urandom_range(3), $urandom_range(3) != 0,
            $urandom_range(3), $urandom_range(9) < 7, $urandom_range(9) < 3,
            $urandom_range(99) < 8, $urandom_range(99) < 10);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
